// File: rtl/jtgng_rom_arb.sv
// Four-client ROM arbiter for the game-side SDRAM read port, with a one-word cache per client.
// Slot 0 has strict priority; slots 1..3 are served round-robin.
module jtgng_rom_arb #(
   parameter int unsigned    AW      = 22,
   parameter int unsigned    DW      = 32,
   parameter logic [AW-1:0]  OFFSET1 = '0,
   parameter logic [AW-1:0]  OFFSET2 = '0,
   parameter logic [AW-1:0]  OFFSET3 = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          downloading,
   input  logic          slot0_cs,
   input  logic          slot1_cs,
   input  logic          slot2_cs,
   input  logic          slot3_cs,
   input  logic [AW-1:0] slot0_addr,
   input  logic [AW-1:0] slot1_addr,
   input  logic [AW-1:0] slot2_addr,
   input  logic [AW-1:0] slot3_addr,
   output logic          slot0_ok,
   output logic          slot1_ok,
   output logic          slot2_ok,
   output logic          slot3_ok,
   output logic [DW-1:0] slot0_dout,
   output logic [DW-1:0] slot1_dout,
   output logic [DW-1:0] slot2_dout,
   output logic [DW-1:0] slot3_dout,
   output logic          sdram_req,
   output logic [AW-1:0] sdram_addr,
   input  logic          sdram_ack,
   input  logic          data_rdy,
   input  logic [DW-1:0] data_read,
   output logic          refresh_en
);

   typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

   state_e          r_state, w_state_d;
   logic            r_req, w_req_d;
   logic [AW-1:0]   r_sdram_addr, w_sdram_addr_d;
   logic [AW-1:0]   r_req_addr, w_req_addr_d;
   logic [1:0]      r_gnt, w_gnt_d;
   logic [1:0]      r_rr, w_rr_d;
   logic [3:0]      r_valid;
   logic [AW-1:0]   r_tag  [4];
   logic [DW-1:0]   r_dout [4];

   logic [3:0]      w_cs, w_ok, w_miss;
   logic [AW-1:0]   w_addr [4];
   logic [AW-1:0]   w_eff  [4];
   logic [1:0]      w_c0, w_c1, w_c2, w_pick;
   logic            w_pick_vld;
   logic            w_fill;

   function automatic logic [1:0] f_next(input logic [1:0] k);
      return (k == 2'd3) ? 2'd1 : k + 2'd1;
   endfunction

   assign w_cs   = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
   assign w_addr[0] = slot0_addr;
   assign w_addr[1] = slot1_addr;
   assign w_addr[2] = slot2_addr;
   assign w_addr[3] = slot3_addr;

   // Offset sums wrap modulo 2^AW by truncation.
   assign w_eff[0] = slot0_addr;
   assign w_eff[1] = slot1_addr + OFFSET1;
   assign w_eff[2] = slot2_addr + OFFSET2;
   assign w_eff[3] = slot3_addr + OFFSET3;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_ok[i]   = w_cs[i] & r_valid[i] & (w_addr[i] == r_tag[i]);
         w_miss[i] = w_cs[i] & ~w_ok[i];
      end
   end

   always_comb begin
      w_c0       = r_rr;
      w_c1       = f_next(w_c0);
      w_c2       = f_next(w_c1);
      w_pick_vld = |w_miss;
      w_pick     = 2'd0;
      if (w_miss[0])         w_pick = 2'd0;
      else if (w_miss[w_c0]) w_pick = w_c0;
      else if (w_miss[w_c1]) w_pick = w_c1;
      else if (w_miss[w_c2]) w_pick = w_c2;
   end

   always_comb begin
      w_state_d      = r_state;
      w_req_d        = r_req;
      w_sdram_addr_d = r_sdram_addr;
      w_req_addr_d   = r_req_addr;
      w_gnt_d        = r_gnt;
      w_rr_d         = r_rr;
      w_fill         = 1'b0;
      if (downloading) begin
         w_state_d = StIdle;
         w_req_d   = 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_pick_vld) begin
                  w_state_d      = StReq;
                  w_req_d        = 1'b1;
                  w_sdram_addr_d = w_eff[w_pick];
                  w_req_addr_d   = w_addr[w_pick];
                  w_gnt_d        = w_pick;
                  if (w_pick != 2'd0) w_rr_d = f_next(w_pick);
               end
            end
            StReq: begin
               if (sdram_ack) begin
                  w_req_d = 1'b0;
                  // Ack and data may land in the same cycle.
                  if (data_rdy) begin
                     w_fill    = 1'b1;
                     w_state_d = StIdle;
                  end else begin
                     w_state_d = StWait;
                  end
               end
            end
            StWait: begin
               if (data_rdy) begin
                  w_fill    = 1'b1;
                  w_state_d = StIdle;
               end
            end
            default: w_state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= StIdle;
         r_req        <= 1'b0;
         r_sdram_addr <= '0;
         r_req_addr   <= '0;
         r_gnt        <= 2'd0;
         r_rr         <= 2'd1;
      end else begin
         r_state      <= w_state_d;
         r_req        <= w_req_d;
         r_sdram_addr <= w_sdram_addr_d;
         r_req_addr   <= w_req_addr_d;
         r_gnt        <= w_gnt_d;
         r_rr         <= w_rr_d;
      end
   end

   // The tag keeps the client address, not the offset SDRAM address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         for (int i = 0; i < 4; i++) begin
            r_tag[i]  <= '0;
            r_dout[i] <= '0;
         end
      end else if (downloading) begin
         r_valid <= '0;
      end else if (w_fill) begin
         r_valid[r_gnt] <= 1'b1;
         r_tag[r_gnt]   <= r_req_addr;
         r_dout[r_gnt]  <= data_read;
      end
   end

   assign slot0_ok   = w_ok[0];
   assign slot1_ok   = w_ok[1];
   assign slot2_ok   = w_ok[2];
   assign slot3_ok   = w_ok[3];
   assign slot0_dout = r_dout[0];
   assign slot1_dout = r_dout[1];
   assign slot2_dout = r_dout[2];
   assign slot3_dout = r_dout[3];
   assign sdram_req  = r_req;
   assign sdram_addr = r_sdram_addr;
   assign refresh_en = (r_state == StIdle) & ~w_miss[0] & ~w_miss[1] & ~w_miss[2] & ~w_miss[3]
                       & ~downloading;

endmodule
